gpr_multiport_sb: RTL and testbench

//   Parametrised multi-port general-purpose register file with an integrated

---
 rtl/gpr_multiport_sb.sv | 100 ++++++++++
 tb/tb_gpr_multiport_sb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_multiport_sb.sv
// gpr_multiport_sb: multi-port general-purpose register file with a
// write-back scoreboard.
//  - NRD asynchronous read ports and NWR synchronous write-back ports.
//    On a write-write conflict the highest-numbered port wins.
//  - One pending-write (busy) bit per register. sb_set marks a register
//    busy, and any write-back to that register clears it. When both happen
//    on the same edge, set wins.
//  - Register 0 always reads 0 and is never busy.
//  - Optional macro GPR_BYPASS_EN: read ports forward same-cycle write-back
//    data and the matching busy release. Without it (the default), a read
//    sees a write one cycle later.
module gpr_multiport_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rstn_h,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr,
  output logic [NREG-1:0]     busy_vec
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Next state: ports are applied in ascending order, so the highest-numbered
  // port wins a conflict. sb_set is applied last, so set beats clear.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
        regs_d[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
        busy_d[wr_addr[w*AW +: AW]] = 1'b0;
      end
    end
    if (sb_set && (sb_addr != '0)) begin
      busy_d[sb_addr] = 1'b1;
    end
    // Register 0 is hardwired: it never holds data and is never pending.
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rstn_h) begin
    if (!rstn_h) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Scoreboard output, forced to zero while reset is held low.
  assign busy_vec = rstn_h ? busy_q : '0;

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] val;
    logic            bsy;

    assign addr = rd_addr[gi*AW +: AW];

    // Asynchronous read of the register and busy bit, optionally bypassed.
    always_comb begin
      val = regs_q[addr];
      bsy = busy_q[addr];
`ifdef GPR_BYPASS_EN
      // Ascending scan gives the highest-numbered matching port priority.
      // An sb_set to the same address means a new producer was issued, so
      // the busy bit is not released early.
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && (addr != '0) && (wr_addr[w*AW +: AW] == addr)) begin
          val = wr_data[w*XLEN +: XLEN];
          bsy = (sb_set && (sb_addr == addr)) ? busy_q[addr] : 1'b0;
        end
      end
`endif
    end

    assign rd_data[gi*XLEN +: XLEN] = rstn_h ? val : '0;
    assign rd_busy[gi]              = rstn_h & bsy;
  end

endmodule

// File: tb/tb_gpr_multiport_sb.sv
// Testbench for gpr_multiport_sb. A spec-level model of the registers and
// busy bits computes the expected read results when stimulus is applied.
// Those expectations are queued and then compared against the DUT outputs
// at the following falling edge. Directed checks cover the listed corner
// cases, and a random phase follows them.
module tb_gpr_multiport_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rstn_h = 1'b0;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en = '0;
  logic [NWR*AW-1:0]   wr_addr = '0;
  logic [NWR*XLEN-1:0] wr_data = '0;
  logic                sb_set = 1'b0;
  logic [AW-1:0]       sb_addr = '0;
  logic [NREG-1:0]     busy_vec;

  gpr_multiport_sb #(
    .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)
  ) dut (
    .clk(clk), .rstn_h(rstn_h),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set(sb_set), .sb_addr(sb_addr), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  logic [XLEN-1:0] m_regs [NREG];
  logic [NREG-1:0] m_busy = '0;
  logic [63:0]     exp_q [$];
  string           tag_q [$];
  int              n_checks = 0;
  int              n_errors = 0;
  int              txn = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    m_busy = '0;
  endtask

  // Expected read-port values for the inputs currently driven.
  task automatic model_read(input int p, output logic [XLEN-1:0] v, output logic b);
    logic [AW-1:0] a;
    a = rd_addr[p*AW +: AW];
    v = m_regs[a];
    b = m_busy[a];
`ifdef GPR_BYPASS_EN
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && a != 0 && wr_addr[w*AW +: AW] == a) begin
        v = wr_data[w*XLEN +: XLEN];
        b = (sb_set && sb_addr == a) ? m_busy[a] : 1'b0;
      end
    end
`endif
    if (!rstn_h) begin
      v = '0;
      b = 1'b0;
    end
  endtask

  // Model state change at a rising edge.
  task automatic model_update();
    logic [AW-1:0] a;
    if (!rstn_h) return;
    for (int w = 0; w < NWR; w++) begin
      a = wr_addr[w*AW +: AW];
      if (wr_en[w] && a != 0) begin
        m_regs[a] = wr_data[w*XLEN +: XLEN];
        m_busy[a] = 1'b0;
      end
    end
    if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
  endtask

  task automatic push_expected();
    logic [XLEN-1:0] v;
    logic b;
    for (int p = 0; p < NRD; p++) begin
      model_read(p, v, b);
      exp_q.push_back({32'b0, v});
      tag_q.push_back($sformatf("txn%0d_rd_data%0d", txn, p));
      exp_q.push_back({63'b0, b});
      tag_q.push_back($sformatf("txn%0d_rd_busy%0d", txn, p));
    end
    exp_q.push_back({32'b0, (rstn_h ? m_busy : 32'b0)});
    tag_q.push_back($sformatf("txn%0d_busy_vec", txn));
  endtask

  task automatic pop_compare();
    for (int p = 0; p < NRD; p++) begin
      check(tag_q.pop_front(), {32'b0, rd_data[p*XLEN +: XLEN]}, exp_q.pop_front());
      check(tag_q.pop_front(), {63'b0, rd_busy[p]}, exp_q.pop_front());
    end
    check(tag_q.pop_front(), {32'b0, busy_vec}, exp_q.pop_front());
  endtask

  // One transaction. It is entered at posedge+1 with the inputs already
  // driven, and it returns at the next posedge+1 with the writes and sets
  // dropped.
  task automatic step();
    push_expected();
    @(negedge clk);
    pop_compare();
    $display("txn %0d rst_n=%b wr_en=%b wr_addr=%h sb=%b/%0d rd_addr=%h rd_data=%h busy_vec=%h",
             txn, rstn_h, wr_en, wr_addr, sb_set, sb_addr, rd_addr, rd_data, busy_vec);
    txn++;
    @(posedge clk);
    model_update();
    #1;
    wr_en  = '0;
    sb_set = 1'b0;
  endtask

  task automatic wr(input int w, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en[w] = 1'b1;
    wr_addr[w*AW +: AW] = a;
    wr_data[w*XLEN +: XLEN] = d;
  endtask

  task automatic sb(input logic [AW-1:0] a);
    sb_set  = 1'b1;
    sb_addr = a;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_clear();
    #1;
    check("reset_busy_vec", {32'b0, busy_vec}, 64'h0);
    check("reset_rd_data0", {32'b0, rd_data[31:0]}, 64'h0);
    #11;
    rstn_h = 1'b1;
    @(posedge clk); #1;

    // Case 2: write-write conflict on r7, where port 1 wins.
    wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22); rd(0, 5'd7);
    step();
    #1; check("ww_conflict_r7", {32'b0, rd_data[31:0]}, 64'h22);

    // Case 3: sb_set r3, then a write-back clears busy and updates data.
    sb(5'd3);
    step();
    check("sb_set_r3", {63'b0, busy_vec[3]}, 64'h1);
    wr(0, 5'd3, 32'h55);
    step();
    check("sb_clear_r3", {63'b0, busy_vec[3]}, 64'h0);
    rd(1, 5'd3); #1;
    check("r3_data", {32'b0, rd_data[63:32]}, 64'h55);

    // Case 4: set and clear on the busy r9 in the same cycle, where set wins.
    sb(5'd9);
    step();
    sb(5'd9); wr(1, 5'd9, 32'h99);
    step();
    check("set_wins_r9", {63'b0, busy_vec[9]}, 64'h1);

    // Case 5: writes and sb_set to r0 are ignored.
    wr(0, 5'd0, 32'hFFFF_FFFF); sb(5'd0); rd(0, 5'd0);
    step();
    #1;
    check("r0_data", {32'b0, rd_data[31:0]}, 64'h0);
    check("r0_busy", {63'b0, busy_vec[0]}, 64'h0);
    check("r0_rd_busy", {63'b0, rd_busy[0]}, 64'h0);

    // Case 6: read and write r4 in the same cycle.
    wr(0, 5'd4, 32'hA5); rd(0, 5'd4); #1;
`ifdef GPR_BYPASS_EN
    check("raw_same_cycle", {32'b0, rd_data[31:0]}, 64'hA5);
`else
    check("raw_same_cycle", {32'b0, rd_data[31:0]}, 64'h0);
`endif
    step();
    check("raw_next_cycle", {32'b0, rd_data[31:0]}, 64'hA5);

    // Case 1: load r5, then assert reset mid-run with a write in flight.
    wr(0, 5'd5, 32'hDEAD_BEEF); sb(5'd5); rd(0, 5'd5);
    step();
    #1;
    check("r5_loaded", {32'b0, rd_data[31:0]}, 64'hDEAD_BEEF);
    check("r5_busy", {63'b0, busy_vec[5]}, 64'h1);
    wr(1, 5'd6, 32'h1234); sb(5'd6);
    rstn_h = 1'b0;
    #1;
    check("midrst_rd_data", {32'b0, rd_data[31:0]}, 64'h0);
    check("midrst_busy_vec", {32'b0, busy_vec}, 64'h0);
    model_clear();
    step();
    rstn_h = 1'b1;
    rd(1, 5'd6);
    #1;
    check("post_rst_r5", {32'b0, rd_data[31:0]}, 64'h0);
    check("post_rst_r6", {32'b0, rd_data[63:32]}, 64'h0);
    check("post_rst_busy_vec", {32'b0, busy_vec}, 64'h0);

    // Random traffic over a narrow address range to provoke conflicts.
    for (int n = 0; n < 300; n++) begin
      for (int p = 0; p < NRD; p++) rd(p, 5'($urandom_range(0, 9)));
      for (int w = 0; w < NWR; w++) begin
        if ($urandom_range(0, 1) == 1) wr(w, 5'($urandom_range(0, 9)), $urandom);
      end
      if ($urandom_range(0, 2) == 0) sb(5'($urandom_range(0, 9)));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
